// File: rtl/nibble_serial_adder_ctrl_if.sv
// Bundle between the serial-add controller, its requester and the external 4-bit adder.
// The requester side also models the adder, so it owns add_sum/add_cout.
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;

    modport master (
        output start, op_a, op_b, cin, add_sum, add_cout,
        input  busy, done, result, cout, add_a, add_b, add_cin
    );

    modport slave (
        input  start, op_a, op_b, cin, add_sum, add_cout,
        output busy, done, result, cout, add_a, add_b, add_cin
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two WIDTH-bit operands through one external 4-bit adder, one nibble per
// clock LSB first, chaining the carry between nibbles through a register.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input logic                    clk,
    input logic                    rst,
    nibble_serial_adder_ctrl_if.slave bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             accept;
    logic             last;

    // DONE accepts a new request exactly like IDLE, giving back-to-back operation.
    assign accept = bus.start && ((state == IDLE) || (state == DONE));
    assign last   = (idx == LAST_IDX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else if (accept) begin
            idx      <= '0;
            carry    <= bus.cin;
            a_q      <= bus.op_a;
            b_q      <= bus.op_b;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else if (state == RUN) begin
            result_q[{idx, 2'b00} +: 4] <= bus.add_sum;
            carry                       <= bus.add_cout;
            if (last) begin
                idx    <= '0;
                cout_q <= bus.add_cout;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Adder operands come from registers only, never straight from start/op_*.
    always_comb begin
        bus.busy    = (state == RUN);
        bus.done    = (state == DONE);
        bus.add_a   = 4'h0;
        bus.add_b   = 4'h0;
        bus.add_cin = 1'b0;
        if (state == RUN) begin
            bus.add_a   = a_q[{idx, 2'b00} +: 4];
            bus.add_b   = b_q[{idx, 2'b00} +: 4];
            bus.add_cin = carry;
        end
    end

    assign bus.result = result_q;
    assign bus.cout   = cout_q;
endmodule
